multicycle_ctrl_fsm: RTL
========================

Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the NPC RV32I core. Successor to the purely combinational control generator.
- Adds an instruction-fetch handshake and registered decode of the full RV32I base opcode set.
- Sequences FETCH/DECODE/EXEC/MEM/WB, handshakes with the LSU, and has a memory timeout and a sticky trap state.
- Sits between the IFU/LSU and the datapath; the datapath consumes the registered control fields.

Parameters:
- MEM_WAIT_MAX, 255: max cycles in MEM awaiting lsu_done before the timeout trap (1..65535).
- CNT_W, 16: width of the MEM wait counter; must satisfy 2^CNT_W > MEM_WAIT_MAX.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inst  in  32  instruction from IFU; valid when inst_valid.
- inst_valid  in  1  IFU has an instruction.
- inst_ready  out  1  FSM accepts an instruction (FETCH only).
- lsu_req  out  1  memory access request; held through MEM.
- lsu_done  in  1  LSU access complete (1-cycle pulse).
- ExtOP  out  3  immediate type: 000 I, 001 U, 010 S, 011 B, 100 J.
- RegWr  out  1  instruction writes rd (registered level).
- ALUAsrc  out  1  0 rs1, 1 PC.
- ALUBsrc  out  2  00 rs2, 01 imm, 10 constant 4.
- ALUctr  out  4  ALU op.
- Branch  out  3  000 none, 001 jal, 010 jalr, 100 beq, 101 bne, 110 blt/bltu, 111 bge/bgeu.
- MemtoReg  out  1  load.
- MemWr  out  1  store.
- MemOP  out  3  equals func3 for loads/stores, else 000.
- reg_wr_en  out  1  1-cycle register-file write strobe in WB.
- pc_wr  out  1  1-cycle PC update strobe in WB.
- trap  out  1  sticky halt indicator.
- trap_cause  out  2  01 illegal, 10 ebreak, 11 mem timeout, 00 none.

Behaviour:
- Reset (async, rst_n=0): state=FETCH; all outputs 0, including inst_ready. inst_ready rises in the first cycle after reset release. The wait counter is cleared.
- FETCH:
  - inst_ready=1.
  - On inst_valid&inst_ready: latch inst, go to DECODE.
  - No transfer: stay.
- DECODE (1 cycle): control outputs are registered from the latched inst and held until the next DECODE. Decode rules:
  - OP-IMM (0010011): ExtOP=000, ALUBsrc=01, RegWr=1, ALUctr={inst[30]&(func3==101),func3}. Example: addi gives ExtOP=000, RegWr=1, ALUAsrc=0, ALUBsrc=01, ALUctr=0000.
  - OP (0110011): ALUBsrc=00, RegWr=1, ALUctr={inst[30],func3}.
  - LUI: ExtOP=001, ALUBsrc=01, ALUctr=1111 (pass B), RegWr=1.
  - AUIPC: ExtOP=001, ALUAsrc=1, ALUBsrc=01, ALUctr=0000, RegWr=1.
  - JAL: ExtOP=100, ALUAsrc=1, ALUBsrc=10, ALUctr=0000, Branch=001, RegWr=1.
  - JALR: ExtOP=000, ALUAsrc=1, ALUBsrc=10, ALUctr=0000, Branch=010, RegWr=1.
  - BRANCH: ExtOP=011, ALUBsrc=00, RegWr=0.
    - ALUctr: 1000 (sub) for beq/bne; 0010 for blt/bge; 0011 for bltu/bgeu.
    - Branch per the encoding above.
  - LOAD: ExtOP=000, ALUBsrc=01, ALUctr=0000, MemtoReg=1, RegWr=1, MemOP=func3.
  - STORE: ExtOP=010, ALUBsrc=01, ALUctr=0000, MemWr=1, MemOP=func3.
  - ebreak (0x00100073): go to TRAP, cause 10.
  - Any other encoding: go to TRAP, cause 01. This includes inst[1:0]!=11, undefined func3 for LOAD/STORE/BRANCH, OP with func7 not in {0000000, 0100000}, and illegal shift func7.
  - Otherwise go to EXEC.
- EXEC (1 cycle): go to MEM if MemtoReg|MemWr, else WB.
- MEM:
  - lsu_req=1 every cycle in MEM. The counter increments each MEM cycle.
  - lsu_done: go to WB, clear the counter, lsu_req low next cycle.
  - Counter reaches MEM_WAIT_MAX without lsu_done: go to TRAP, cause 11.
  - lsu_done in the same cycle the counter hits the limit: lsu_done wins.
- WB (1 cycle): pc_wr=1; reg_wr_en=RegWr. Next state FETCH.
- TRAP:
  - trap=1, trap_cause held, inst_ready=0, lsu_req=0, strobes 0.
  - Exit only via reset.
- Minimum latency, fetch-accept to WB:
  - Non-memory: 3 cycles (DECODE, EXEC, WB).
  - Memory: 3 + MEM cycles.
- lsu_done outside MEM: ignored. inst_valid outside FETCH: ignored.
- Reset asserted mid-operation: immediate return to reset state. An in-flight lsu_req drops asynchronously.

Optional Feature:
- Macro CTRL_FSM_PERF_EN.
- Defined:
  - Adds output port retired (32 bits), reset 0.
  - retired increments on every WB cycle and wraps 0xFFFFFFFF to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- addi x1,x0,5 (0x00500093) presented after reset:
  - inst_ready 1 in the first cycle after reset release.
  - After accept: ExtOP=000, RegWr=1, ALUBsrc=01, ALUctr=0000.
  - reg_wr_en and pc_wr high exactly 1 cycle, 3 cycles after accept.
- sub x3,x1,x2 (0x402081B3): ALUctr=1000, ALUBsrc=00. bne (0x00209463): Branch=101, ALUctr=1000, RegWr=0, reg_wr_en=0 in WB.
- lw x5,0(x1) (0x0000A283), lsu_done after 4 MEM cycles:
  - lsu_req high 4 cycles, MemtoReg=1, MemOP=010.
  - WB 1 cycle later.
  - Repeat with lsu_done on exactly the MEM_WAIT_MAX-th cycle: no trap.
- sw with lsu_done never asserted, MEM_WAIT_MAX=8: trap=1, trap_cause=11 after 8 MEM cycles. The FSM stays trapped with inst_ready=0 until rst_n pulse.
- 0x00000000 gives trap_cause=01; 0x00100073 gives trap_cause=10. Neither asserts pc_wr or reg_wr_en.
- rst_n pulsed low mid-MEM: lsu_req and all outputs 0 asynchronously. inst_ready=1 in the first cycle after release. With CTRL_FSM_PERF_EN, retired=0.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with LSU handshake, MEM timeout and sticky trap.
// Optional retired-instruction counter when CTRL_FSM_PERF_EN is defined.
//   state  | meaning
//   FETCH  | inst_ready high, wait for inst_valid
//   DECODE | register control fields from latched inst, detect illegal/ebreak
//   EXEC   | one cycle, choose MEM or WB
//   MEM    | lsu_req high, wait lsu_done or timeout
//   WB     | pc_wr / reg_wr_en strobes
//   TRAP   | sticky halt, exit only via reset
module multicycle_ctrl_fsm #(
    parameter int unsigned MEM_WAIT_MAX = 255,
    parameter int unsigned CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        inst_valid,
    output logic        inst_ready,
    output logic        lsu_req,
    input  logic        lsu_done,
    output logic [2:0]  ExtOP,
    output logic        RegWr,
    output logic        ALUAsrc,
    output logic [1:0]  ALUBsrc,
    output logic [3:0]  ALUctr,
    output logic [2:0]  Branch,
    output logic        MemtoReg,
    output logic        MemWr,
    output logic [2:0]  MemOP,
    output logic        reg_wr_en,
    output logic        pc_wr,
    output logic        trap,
    output logic [1:0]  trap_cause
`ifdef CTRL_FSM_PERF_EN
    ,output logic [31:0] retired
`endif
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

    state_t r_state, w_next;
    logic [31:0] r_inst;
    logic [CNT_W-1:0] r_cnt;
    logic r_inst_ready, r_regwr, r_alua, r_memtoreg, r_memwr;
    logic [2:0] r_extop, r_branch, r_memop;
    logic [1:0] r_alub, r_cause, w_cause;
    logic [3:0] r_aluctr;
    logic w_accept;

    logic [6:0] w_opc, w_f7;
    logic [2:0] w_f3, w_extop, w_branch, w_memop;
    logic [1:0] w_alub;
    logic [3:0] w_aluctr;
    logic w_regwr, w_alua, w_memtoreg, w_memwr, w_illegal, w_ebreak;

    assign w_opc    = r_inst[6:0];
    assign w_f3     = r_inst[14:12];
    assign w_f7     = r_inst[31:25];
    assign w_accept = (r_state == S_FETCH) && inst_valid && r_inst_ready;

    always_comb begin
        w_extop = 3'b000; w_regwr = 1'b0; w_alua = 1'b0; w_alub = 2'b00;
        w_aluctr = 4'b0000; w_branch = 3'b000; w_memtoreg = 1'b0; w_memwr = 1'b0;
        w_memop = 3'b000; w_illegal = 1'b0; w_ebreak = 1'b0;
        case (w_opc)
            7'b0010011: begin
                w_alub = 2'b01; w_regwr = 1'b1;
                w_aluctr = {r_inst[30] & (w_f3 == 3'b101), w_f3};
                if (w_f3 == 3'b001 && w_f7 != 7'b0000000) w_illegal = 1'b1;
                if (w_f3 == 3'b101 && w_f7 != 7'b0000000 && w_f7 != 7'b0100000) w_illegal = 1'b1;
            end
            7'b0110011: begin
                w_regwr = 1'b1; w_aluctr = {r_inst[30], w_f3};
                // the alternate func7 only exists for sub and sra
                if (!(w_f7 == 7'b0000000 ||
                      (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))))
                    w_illegal = 1'b1;
            end
            7'b0110111: begin
                w_extop = 3'b001; w_alub = 2'b01; w_aluctr = 4'b1111; w_regwr = 1'b1;
            end
            7'b0010111: begin
                w_extop = 3'b001; w_alua = 1'b1; w_alub = 2'b01; w_regwr = 1'b1;
            end
            7'b1101111: begin
                w_extop = 3'b100; w_alua = 1'b1; w_alub = 2'b10; w_branch = 3'b001; w_regwr = 1'b1;
            end
            7'b1100111: begin
                w_alua = 1'b1; w_alub = 2'b10; w_branch = 3'b010; w_regwr = 1'b1;
                if (w_f3 != 3'b000) w_illegal = 1'b1;
            end
            7'b1100011: begin
                w_extop = 3'b011;
                case (w_f3)
                    3'b000:  begin w_branch = 3'b100; w_aluctr = 4'b1000; end
                    3'b001:  begin w_branch = 3'b101; w_aluctr = 4'b1000; end
                    3'b100:  begin w_branch = 3'b110; w_aluctr = 4'b0010; end
                    3'b101:  begin w_branch = 3'b111; w_aluctr = 4'b0010; end
                    3'b110:  begin w_branch = 3'b110; w_aluctr = 4'b0011; end
                    3'b111:  begin w_branch = 3'b111; w_aluctr = 4'b0011; end
                    default: w_illegal = 1'b1;
                endcase
            end
            7'b0000011: begin
                w_alub = 2'b01; w_memtoreg = 1'b1; w_regwr = 1'b1; w_memop = w_f3;
                if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111) w_illegal = 1'b1;
            end
            7'b0100011: begin
                w_extop = 3'b010; w_alub = 2'b01; w_memwr = 1'b1; w_memop = w_f3;
                if (w_f3 > 3'b010) w_illegal = 1'b1;
            end
            7'b1110011: begin
                if (r_inst == 32'h0010_0073) w_ebreak = 1'b1;
                else                         w_illegal = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_cause = 2'b00;
        case (r_state)
            S_FETCH:  if (w_accept) w_next = S_DECODE;
            S_DECODE: begin
                if (w_ebreak)       begin w_next = S_TRAP; w_cause = 2'b10; end
                else if (w_illegal) begin w_next = S_TRAP; w_cause = 2'b01; end
                else                w_next = S_EXEC;
            end
            S_EXEC:   w_next = (r_memtoreg | r_memwr) ? S_MEM : S_WB;
            S_MEM: begin
                if (lsu_done)                  w_next = S_WB;
                else if (r_cnt == LP_CNT_LAST) begin w_next = S_TRAP; w_cause = 2'b11; end
            end
            S_WB:     w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        lsu_req   = (r_state == S_MEM);
        pc_wr     = (r_state == S_WB);
        reg_wr_en = (r_state == S_WB) & r_regwr;
        trap      = (r_state == S_TRAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst_ready <= 1'b0; r_inst <= '0; r_cnt <= '0; r_cause <= 2'b00;
            r_extop <= 3'b000; r_regwr <= 1'b0; r_alua <= 1'b0; r_alub <= 2'b00;
            r_aluctr <= 4'b0000; r_branch <= 3'b000; r_memtoreg <= 1'b0;
            r_memwr <= 1'b0; r_memop <= 3'b000;
        end else begin
            r_inst_ready <= (w_next == S_FETCH);
            if (w_accept) r_inst <= inst;
            if (r_state == S_DECODE) begin
                r_extop <= w_extop; r_regwr <= w_regwr; r_alua <= w_alua; r_alub <= w_alub;
                r_aluctr <= w_aluctr; r_branch <= w_branch; r_memtoreg <= w_memtoreg;
                r_memwr <= w_memwr; r_memop <= w_memop;
            end
            if (r_state == S_MEM && w_next == S_MEM) r_cnt <= r_cnt + 1'b1;
            else                                     r_cnt <= '0;
            if (r_state != S_TRAP && w_next == S_TRAP) r_cause <= w_cause;
        end
    end

`ifdef CTRL_FSM_PERF_EN
    logic [31:0] r_retired;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_retired <= '0;
        else if (r_state == S_WB)  r_retired <= r_retired + 32'd1;
    end
    assign retired = r_retired;
`endif

    assign inst_ready = r_inst_ready;
    assign trap_cause = r_cause;
    assign ExtOP      = r_extop;
    assign RegWr      = r_regwr;
    assign ALUAsrc    = r_alua;
    assign ALUBsrc    = r_alub;
    assign ALUctr     = r_aluctr;
    assign Branch     = r_branch;
    assign MemtoReg   = r_memtoreg;
    assign MemWr      = r_memwr;
    assign MemOP      = r_memop;

endmodule
